// File: rtl/pcihellocore_led_out.sv
// pcihellocore_led_out
// Avalon-MM slave driving a 32-bit output register (LEDs/GPIO) with
// byte-enabled DATA writes, atomic set/clear, and a self-clearing timed
// pulse. Read data is registered from a free-running address mux, and a
// one-cycle strobe flags every change of the output register.
//
// Register map (word addresses):
//   0 DATA      write: merge writedata under byteenable, cancels pulses on those bits
//                read : out_port
//   4 OUTSET    write: out_port |= data
//   5 OUTCLEAR  write: out_port &= ~data, cancels pulses on those bits
//   6 PULSE     write: set bits and arm a PULSE_CYCLES timer for them
//                read : pulse_mask
//   7 (count)   read : pulse_cnt
//   1,2,3       writes ignored, read as zero

module pcihellocore_led_out #(
  parameter logic [31:0] RESET_VALUE  = 32'h0,
  parameter logic [31:0] PULSE_CYCLES = 32'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic [31:0] out_port,
  output logic        out_changed
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_PULSE    = 3'd6;
  localparam logic [2:0] ADDR_COUNT    = 3'd7;

  logic [31:0] out_port_q,    out_port_d;
  logic [31:0] pulse_mask_q,  pulse_mask_d;
  logic [31:0] pulse_cnt_q,   pulse_cnt_d;
  logic [31:0] readdata_q,    readdata_d;
  logic        out_changed_q, out_changed_d;

  logic        wr_en;
  logic [31:0] be_mask;
  logic [31:0] wr_bits;
  logic        pulse_active;
  logic        pulse_expire;

  assign wr_en        = chipselect & ~write_n;
  assign be_mask      = {{8{byteenable[3]}}, {8{byteenable[2]}},
                         {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign wr_bits      = writedata & be_mask;
  assign pulse_active = (pulse_mask_q != 32'h0);
  assign pulse_expire = pulse_active && (pulse_cnt_q == 32'h0);

  // Next-state for output, pulse mask and pulse counter: timer first, then the bus write.
  always_comb begin
    // NOTE: every target gets a default up front so no path leaves it unassigned (no latch).
    out_port_d   = out_port_q;
    pulse_mask_d = pulse_mask_q;
    pulse_cnt_d  = pulse_cnt_q;

    // Counter runs only while some bit is pulsing; otherwise it holds.
    if (pulse_active && (pulse_cnt_q != 32'h0)) begin
      pulse_cnt_d = pulse_cnt_q - 32'd1;
    end

    // Expiry is applied before the write so a same-cycle write wins on its bits.
    if (pulse_expire) begin
      out_port_d   = out_port_q & ~pulse_mask_q;
      pulse_mask_d = 32'h0;
    end

    if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          out_port_d   = (out_port_d & ~be_mask) | wr_bits;
          pulse_mask_d = pulse_mask_d & ~be_mask;
        end
        ADDR_OUTSET: begin
          out_port_d = out_port_d | wr_bits;
        end
        ADDR_OUTCLEAR: begin
          out_port_d   = out_port_d & ~wr_bits;
          pulse_mask_d = pulse_mask_d & ~wr_bits;
        end
        ADDR_PULSE: begin
          // Retrigger restarts the shared count for every masked bit.
          out_port_d   = out_port_d | wr_bits;
          pulse_mask_d = pulse_mask_d | wr_bits;
          if (wr_bits != 32'h0) begin
            pulse_cnt_d = PULSE_CYCLES - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux is sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = 32'h0;
    case (address)
      ADDR_DATA:  readdata_d = out_port_q;
      ADDR_PULSE: readdata_d = pulse_mask_q;
      ADDR_COUNT: readdata_d = pulse_cnt_q;
      default:    readdata_d = 32'h0;
    endcase
  end

  // Change strobe lines up with the cycle in which the new out_port value appears.
  always_comb begin
    out_changed_d = (out_port_d != out_port_q);
  end

  // State registers; reset aborts any pulse in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: async active-low reset in the sensitivity list; state updates use <= so all flops sample pre-edge values.
    if (!reset_n) begin
      out_port_q    <= RESET_VALUE;
      pulse_mask_q  <= 32'h0;
      pulse_cnt_q   <= 32'h0;
      readdata_q    <= 32'h0;
      out_changed_q <= 1'b0;
    end else begin
      out_port_q    <= out_port_d;
      pulse_mask_q  <= pulse_mask_d;
      pulse_cnt_q   <= pulse_cnt_d;
      readdata_q    <= readdata_d;
      out_changed_q <= out_changed_d;
    end
  end

  assign readdata    = readdata_q;
  assign out_port    = out_port_q;
  assign out_changed = out_changed_q;

endmodule

// File: tb/tb_pcihellocore_led_out.sv
// Testbench for pcihellocore_led_out: directed bus cycles, each carrying a
// hand-computed expectation for the state right after its clock edge. The
// driver queues expectations; a monitor pops one every falling edge and
// compares out_port, out_changed and readdata.

module tb_pcihellocore_led_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        out_changed;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        chg;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pcihellocore_led_out #(
    .RESET_VALUE (32'h0000_00A5),
    .PULSE_CYCLES(32'd4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_changed(out_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_now(input string nm, input logic [31:0] eo, input logic ec,
                            input logic [31:0] erd);
    exp_t e;
    e.name = nm;
    e.out  = eo;
    e.chg  = ec;
    e.rd   = erd;
    sb.push_back(e);
  endtask

  // One bus cycle; the expectation describes the state just after this edge.
  task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [3:0] be, input string nm,
                      input logic [31:0] eo, input logic ec, input logic [31:0] erd);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    byteenable = be;
    @(posedge clk);
    #1;
    expect_now(nm, eo, ec, erd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be,
                    input string nm, input logic [31:0] eo, input logic ec,
                    input logic [31:0] erd);
    step(a, 1'b1, 1'b0, wd, be, nm, eo, ec, erd);
  endtask

  task automatic idle(input logic [2:0] a, input string nm, input logic [31:0] eo,
                      input logic ec, input logic [31:0] erd);
    step(a, 1'b0, 1'b1, 32'h0, 4'h0, nm, eo, ec, erd);
  endtask

  // Monitor: one expectation per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".out_port"},    out_port,           e.out);
        check({e.name, ".out_changed"}, {31'h0, out_changed}, {31'h0, e.chg});
        check({e.name, ".readdata"},    readdata,           e.rd);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    byteenable = 4'h0;
    #1;
    expect_now("reset", 32'hA5, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;

    // First write right after reset release, then the DATA byte-merge case.
    wr(3'd0, 32'h0000_0000, 4'hF,    "first_wr",  32'h0000_0000, 1'b1, 32'hA5);
    wr(3'd0, 32'h1234_5678, 4'b0101, "data_be",   32'h0034_0078, 1'b1, 32'h0);
    idle(3'd0,                        "data_hold", 32'h0034_0078, 1'b0, 32'h0034_0078);
    idle(3'd3,                        "rd_addr3",  32'h0034_0078, 1'b0, 32'h0);

    // Set/clear, including a no-op repeat and ignored/unselected writes.
    wr(3'd0, 32'h0,  4'hF, "clr_all",   32'h0,  1'b1, 32'h0034_0078);
    wr(3'd4, 32'hF0, 4'hF, "outset",    32'hF0, 1'b1, 32'h0);
    wr(3'd5, 32'h30, 4'hF, "outclear",  32'hC0, 1'b1, 32'h0);
    wr(3'd5, 32'h30, 4'hF, "outclr_rep",32'hC0, 1'b0, 32'h0);
    idle(3'd0,             "rd_c0",     32'hC0, 1'b0, 32'hC0);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF, "ign_a1", 32'hC0, 1'b0, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF, 4'hF, "ign_a7", 32'hC0, 1'b0, 32'h0);
    wr(3'd4, 32'hFFFF_FFFF, 4'b1000, "set_b3", 32'hFF00_00C0, 1'b1, 32'h0);
    wr(3'd5, 32'hFFFF_FFFF, 4'b1000, "clr_b3", 32'h0000_00C0, 1'b1, 32'h0);
    step(3'd0, 1'b0, 1'b0, 32'h0, 4'hF, "no_cs", 32'hC0, 1'b0, 32'hC0);
    wr(3'd0, 32'h0, 4'hF, "clr_all2", 32'h0, 1'b1, 32'hC0);

    // Timed pulse: bit0 high for exactly 4 cycles.
    wr(3'd6, 32'h1, 4'hF, "pulse",    32'h1, 1'b1, 32'h0);
    idle(3'd6,            "pulse_c1", 32'h1, 1'b0, 32'h1);
    idle(3'd7,            "pulse_c2", 32'h1, 1'b0, 32'h2);
    idle(3'd6,            "pulse_c3", 32'h1, 1'b0, 32'h1);
    idle(3'd6,            "pulse_end",32'h0, 1'b1, 32'h1);
    idle(3'd6,            "pulse_mk0",32'h0, 1'b0, 32'h0);
    idle(3'd7,            "pulse_cnt0",32'h0, 1'b0, 32'h0);

    // Retrigger two cycles after the first pulse: both bits expire together.
    wr(3'd6, 32'h1, 4'hF, "retrig_w1", 32'h1, 1'b1, 32'h0);
    idle(3'd0,            "retrig_h1", 32'h1, 1'b0, 32'h1);
    wr(3'd6, 32'h2, 4'hF, "retrig_w2", 32'h3, 1'b1, 32'h1);
    idle(3'd6,            "retrig_mk", 32'h3, 1'b0, 32'h3);
    idle(3'd7,            "retrig_cnt",32'h3, 1'b0, 32'h2);
    idle(3'd0,            "retrig_h3", 32'h3, 1'b0, 32'h3);
    idle(3'd6,            "retrig_end",32'h0, 1'b1, 32'h3);
    idle(3'd6,            "retrig_mk0",32'h0, 1'b0, 32'h0);

    // DATA write landing on the expiry cycle: written bit wins.
    wr(3'd6, 32'h3, 4'hF, "coll_p",   32'h3, 1'b1, 32'h0);
    idle(3'd7,            "coll_c1",  32'h3, 1'b0, 32'h3);
    idle(3'd0,            "coll_c2",  32'h3, 1'b0, 32'h3);
    idle(3'd0,            "coll_c3",  32'h3, 1'b0, 32'h3);
    wr(3'd0, 32'h1, 4'hF, "coll_data",32'h1, 1'b1, 32'h3);
    idle(3'd6,            "coll_mk0", 32'h1, 1'b0, 32'h0);
    idle(3'd7,            "coll_cnt0",32'h1, 1'b0, 32'h0);

    // PULSE write landing on the expiry cycle: mask becomes the new bits only.
    wr(3'd0, 32'h0, 4'hF, "pp_clr",   32'h0, 1'b1, 32'h1);
    wr(3'd6, 32'h1, 4'hF, "pp_p1",    32'h1, 1'b1, 32'h0);
    idle(3'd0,            "pp_c1",    32'h1, 1'b0, 32'h1);
    idle(3'd0,            "pp_c2",    32'h1, 1'b0, 32'h1);
    idle(3'd0,            "pp_c3",    32'h1, 1'b0, 32'h1);
    wr(3'd6, 32'h2, 4'hF, "pp_p2",    32'h2, 1'b1, 32'h1);
    idle(3'd6,            "pp_mask",  32'h2, 1'b0, 32'h2);
    idle(3'd7,            "pp_cnt",   32'h2, 1'b0, 32'h2);
    idle(3'd0,            "pp_c3b",   32'h2, 1'b0, 32'h2);
    idle(3'd0,            "pp_end",   32'h0, 1'b1, 32'h2);
    wr(3'd6, 32'hFF, 4'h0, "pulse_be0", 32'h0, 1'b0, 32'h0);

    // Reset asserted mid-pulse: no expiry afterwards may touch the reset value.
    wr(3'd6, 32'hFF, 4'hF, "rp_pulse", 32'hFF, 1'b1, 32'h0);
    idle(3'd7,             "rp_c1",    32'hFF, 1'b0, 32'h3);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    expect_now("rp_reset", 32'hA5, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    idle(3'd6, "rp_mask0", 32'hA5, 1'b0, 32'h0);
    idle(3'd7, "rp_cnt0",  32'hA5, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(3'd0, "rp_hold", 32'hA5, 1'b0, 32'hA5);
    end

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
